// File: rtl/sysbus_pkg.sv
// Shared sysbus definitions: tag field layout, op/target encodings, responder states.
package sysbus_pkg;

  localparam int OP_BIT  = 12;
  localparam int TGT_MSB = 11;
  localparam int TGT_LSB = 8;

  localparam logic       SYSBUS_READ   = 1'b1;
  localparam logic       SYSBUS_WRITE  = 1'b0;
  localparam logic [3:0] SYSBUS_MEMORY = 4'h1;

  typedef enum logic [1:0] {IDLE, WAIT, RDATA, WDATA} mem_state_e;

endpackage

// File: rtl/sysbus_mem_array.sv
// Single-port word store: synchronous write, combinational read.
module sysbus_mem_array #(
  parameter int MEM_WORDS = 4096,
  parameter int DATA_W    = 64,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // No reset on contents; power-up value is whatever the storage holds.
  logic [DATA_W-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  assign rdata = mem[addr];

endmodule

// File: rtl/sysbus_mem_responder.sv
// Memory-side sysbus responder: line reads returned as BURST_LEN-beat bursts, line writes absorbed.
module sysbus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 4096,
  parameter int BURST_LEN      = 8,
  parameter int READ_LATENCY   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int LW = $clog2(READ_LATENCY + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  mem_state_e                state, nstate;
  logic [BW-1:0]             beat_q, beat_d;
  logic [LW-1:0]             lat_q, lat_d;
  logic [AW-1:0]             base_q, base_d;
  logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;

  logic                      reqack_d, respcyc_d;
  logic [BUS_DATA_WIDTH-1:0] resp_d;
  logic [BUS_TAG_WIDTH-1:0]  resptag_d;

  logic                      mem_we;
  logic [AW-1:0]             mem_addr;
  logic [BUS_DATA_WIDTH-1:0] mem_rdata;

  wire req_xfer  = bus_reqcyc && bus_reqack;
  wire resp_xfer = bus_respcyc && bus_respack;
  wire req_mem   = (bus_reqtag[TGT_MSB:TGT_LSB] == SYSBUS_MEMORY);
  wire req_rd    = (bus_reqtag[OP_BIT] == SYSBUS_READ);

  // Low beat bits of the word index are cleared so every request is line aligned.
  wire [AW-1:0] req_base = {bus_req[3+AW-1:3+BW], {BW{1'b0}}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      beat_q      <= '0;
      lat_q       <= '0;
      base_q      <= '0;
      tag_q       <= '0;
      bus_reqack  <= 1'b0;
      bus_respcyc <= 1'b0;
      bus_resp    <= '0;
      bus_resptag <= '0;
    end else begin
      state       <= nstate;
      beat_q      <= beat_d;
      lat_q       <= lat_d;
      base_q      <= base_d;
      tag_q       <= tag_d;
      bus_reqack  <= reqack_d;
      bus_respcyc <= respcyc_d;
      bus_resp    <= resp_d;
      bus_resptag <= resptag_d;
    end
  end

  always_comb begin
    nstate = state;
    beat_d = beat_q;
    lat_d  = lat_q;
    base_d = base_q;
    tag_d  = tag_q;
    mem_we = 1'b0;
    case (state)
      IDLE: begin
        // Requests to other targets are acked and silently dropped.
        if (req_xfer && req_mem) begin
          base_d = req_base;
          tag_d  = bus_reqtag;
          beat_d = '0;
          if (req_rd) begin
            lat_d  = LW'(READ_LATENCY - 1);
            nstate = WAIT;
          end else begin
            nstate = WDATA;
          end
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          nstate = RDATA;
          beat_d = '0;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      RDATA: begin
        if (resp_xfer) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) nstate = IDLE;
        end
      end
      WDATA: begin
        if (req_xfer) begin
          mem_we = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) nstate = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  // Writes use the current beat; reads prefetch the beat that will be shown next cycle.
  always_comb begin
    mem_addr  = (state == WDATA) ? base_q + AW'(beat_q) : base_d + AW'(beat_d);
    reqack_d  = (nstate == IDLE) || (nstate == WDATA);
    respcyc_d = (nstate == RDATA);
    resp_d    = respcyc_d ? mem_rdata : '0;
    resptag_d = respcyc_d ? tag_d : '0;
  end

  sysbus_mem_array #(
    .MEM_WORDS (MEM_WORDS),
    .DATA_W    (BUS_DATA_WIDTH),
    .AW        (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (bus_req),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed bench for sysbus_mem_responder: write/read, backpressure, wrap, drop, reset, back-to-back.
module tb_sysbus_mem_responder;
  localparam int MEM_WORDS = 4096;

  logic        clk, reset;
  logic        bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
  logic [63:0] bus_req, bus_resp;
  logic [12:0] bus_reqtag, bus_resptag;

  int nvec = 0;
  int nmis = 0;

  logic [63:0] line_a [8];
  logic [63:0] line_b [8];
  logic [63:0] line_ab [16];

  sysbus_mem_responder #(
    .BUS_DATA_WIDTH (64),
    .BUS_TAG_WIDTH  (13),
    .MEM_WORDS      (MEM_WORDS),
    .BURST_LEN      (8),
    .READ_LATENCY   (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_reqcyc  (bus_reqcyc),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_reqack  (bus_reqack),
    .bus_respcyc (bus_respcyc),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag),
    .bus_respack (bus_respack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present a request beat and hold it until acked; returns at the negedge after the transfer edge.
  task automatic send_beat(input logic [63:0] d, input logic [12:0] t);
    int n = 0;
    bus_reqcyc = 1'b1;
    bus_req    = d;
    bus_reqtag = t;
    while (!bus_reqack && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("req_timeout", 64'(bus_reqack), 64'd1);
    @(negedge clk);
  endtask

  task automatic wr_line(input logic [63:0] addr, input logic [12:0] t, input logic [63:0] d [8]);
    send_beat(addr, t);
    for (int k = 0; k < 8; k++) send_beat(d[k], t);
    bus_reqcyc = 1'b0;
  endtask

  // mode 0: respack held 1; mode 1: respack pattern 1,0,0 repeating
  task automatic rd_line(input string nm, input logic [63:0] addr, input logic [12:0] t,
                         input int mode, input logic [63:0] exp [8], input bit chk_lat);
    int nb = 0, c = 0, first = -1;
    send_beat(addr, t);
    bus_reqcyc = 1'b0;
    while (nb < 8 && c < 200) begin
      bus_respack = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      if (bus_respcyc) begin
        if (first < 0) first = c + 1;
        chk({nm, "_data"}, bus_resp, exp[nb]);
        chk({nm, "_tag"}, 64'(bus_resptag), 64'(t));
        if (bus_respack) nb++;
      end
      @(negedge clk);
      c++;
    end
    bus_respack = 1'b0;
    chk({nm, "_count"}, 64'(nb), 64'd8);
    chk({nm, "_end"}, 64'(bus_respcyc), 64'd0);
    if (chk_lat) chk({nm, "_latency"}, 64'(first), 64'd5);
  endtask

  initial begin
    int nb, c;
    bit early, b_sent, seen;
    reset = 1'b1;
    bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0; bus_respack = 1'b0;
    for (int k = 0; k < 8; k++) begin
      line_a[k] = 64'h11 * (k + 1);
      line_b[k] = 64'hDEAD_0000_0000_0000 + 64'(k);
      line_ab[k] = line_a[k];
      line_ab[k+8] = line_b[k];
    end

    #3 reset = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_reqack",  64'(bus_reqack),  64'd0);
    chk("rst_respcyc", 64'(bus_respcyc), 64'd0);
    chk("rst_resp",    bus_resp,         64'd0);
    chk("rst_resptag", 64'(bus_resptag), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_reqack", 64'(bus_reqack), 64'd1);

    // write then read back, checking first-beat latency
    wr_line(64'h1000, 13'h0100, line_a);
    chk("wr_idle_ack", 64'(bus_reqack), 64'd1);
    rd_line("rd", 64'h1000, 13'h1105, 0, line_a, 1'b1);

    rd_line("bp", 64'h1000, 13'h1106, 1, line_a, 1'b0);

    // unaligned address and index wrap
    rd_line("unal", 64'h1007, 13'h1107, 0, line_a, 1'b0);
    wr_line(64'(MEM_WORDS * 8 + 64'h40), 13'h0101, line_b);
    rd_line("wrap", 64'h40, 13'h1108, 0, line_b, 1'b1);

    // non-memory target is acked and dropped
    send_beat(64'h1000, 13'h1F05);
    bus_reqcyc = 1'b0;
    bus_respack = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus_respcyc) seen = 1'b1;
      @(negedge clk);
    end
    bus_respack = 1'b0;
    chk("nm_no_resp", 64'(seen), 64'd0);
    chk("nm_reqack",  64'(bus_reqack), 64'd1);
    rd_line("nm_next", 64'h1000, 13'h1109, 0, line_a, 1'b0);

    // async reset after third read beat
    send_beat(64'h1000, 13'h110A);
    bus_reqcyc = 1'b0;
    bus_respack = 1'b1;
    nb = 0; c = 0;
    while (nb < 3 && c < 50) begin
      if (bus_respcyc) nb++;
      @(negedge clk);
      c++;
    end
    chk("rst_mid_pre", 64'(bus_respcyc), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_respcyc", 64'(bus_respcyc), 64'd0);
    chk("rst_mid_reqack",  64'(bus_reqack),  64'd0);
    chk("rst_mid_resp",    bus_resp,         64'd0);
    bus_respack = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    rd_line("post_rst", 64'h1000, 13'h110B, 0, line_a, 1'b1);

    // back-to-back reads with reqcyc held
    send_beat(64'h1000, 13'h1101);
    bus_req = 64'h40; bus_reqtag = 13'h1102;
    bus_respack = 1'b1;
    nb = 0; c = 0; early = 1'b0; b_sent = 1'b0;
    while (nb < 16 && c < 300) begin
      if (bus_reqack && bus_reqcyc) begin
        if (nb < 8) early = 1'b1;
        b_sent = 1'b1;
      end
      if (bus_respcyc) begin
        chk("b2b_data", bus_resp, line_ab[nb]);
        chk("b2b_tag", 64'(bus_resptag), (nb < 8) ? 64'h1101 : 64'h1102);
        nb++;
      end
      @(negedge clk);
      c++;
      if (b_sent) bus_reqcyc = 1'b0;
    end
    bus_respack = 1'b0;
    chk("b2b_early_ack", 64'(early), 64'd0);
    chk("b2b_count", 64'(nb), 64'd16);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
